mmio_io_ctrl: RTL and testbench



---
 rtl/io_pkg.sv | 23 ++
 rtl/mmio_io_ctrl_if.sv | 26 ++
 rtl/io_in_chan.sv | 67 ++++++
 rtl/mmio_io_ctrl.sv | 108 ++++++++++
 tb/tb_mmio_io_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O controller: address layout,
// status bit positions and the input-channel state encoding.
package io_pkg;

    localparam int ADDR_W     = 8;
    localparam int OUT_STRIDE = 4;
    localparam int IN_STRIDE  = 8;
    localparam int STATUS_OFS = 4;

    localparam int ST_FULL = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_t;

    // Byte addresses are word aligned; the two low bits never take part in decode.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & 8'hFC;
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU-side IO bus: address, write data, write/read enables and read data.
interface mmio_io_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        io_addr;
    logic [DATA_W-1:0] io_dout;
    logic              io_we;
    logic              io_rd;
    logic [DATA_W-1:0] io_din;

    modport master (
        output io_addr,
        output io_dout,
        output io_we,
        output io_rd,
        input  io_din
    );

    modport slave (
        input  io_addr,
        input  io_dout,
        input  io_we,
        input  io_rd,
        output io_din
    );
endinterface

// File: rtl/io_in_chan.sv
// One input capture channel: a single-entry buffer with a full flag and a
// sticky overrun flag that software clears through the status register.
module io_in_chan
    import io_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              data_rd,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] buf_data,
    output logic              full,
    output logic              ovr
);

    chan_state_t       state_reg, state_next;
    logic [DATA_W-1:0] buf_reg, buf_next;
    logic              ovr_reg, ovr_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= CH_EMPTY;
            buf_reg   <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        ovr_next   = ovr_reg;
        // Clear is applied first so that a fresh overrun in the same cycle wins.
        if (ovr_clr) begin
            ovr_next = 1'b0;
        end
        case (state_reg)
            CH_EMPTY: begin
                if (in_valid) begin
                    buf_next   = in_data;
                    state_next = CH_FULL;
                end
            end
            CH_FULL: begin
                if (in_valid && data_rd) begin
                    buf_next = in_data;
                end else if (in_valid) begin
                    ovr_next = 1'b1;
                end else if (data_rd) begin
                    state_next = CH_EMPTY;
                end
            end
            default: state_next = CH_EMPTY;
        endcase
    end

    assign buf_data = buf_reg;
    assign full     = (state_reg == CH_FULL);
    assign ovr      = ovr_reg;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: N_OUT writable output registers with write
// strobes and N_IN buffered input channels with full/overrun status.
module mmio_io_ctrl
    import io_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          N_OUT   = 2,
    parameter int          N_IN    = 2,
    parameter logic [7:0]  IN_BASE = 8'h40
) (
    input  logic                    clk,
    input  logic                    rstn,
    mmio_io_ctrl_if.slave           bus,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_strobe,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic                    irq
);

    logic [ADDR_W-1:0] addr_al;
    logic [DATA_W-1:0] out_rd [N_OUT];
    logic [DATA_W-1:0] in_rd  [N_IN];
    logic [N_IN-1:0]   full_vec;

    assign addr_al = word_align(bus.io_addr);

    genvar gi;

    for (gi = 0; gi < N_OUT; gi++) begin : g_out
        localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(OUT_STRIDE * gi);

        logic              sel;
        logic [DATA_W-1:0] data_reg;
        logic              strobe_reg;

        assign sel = (addr_al == ADDR);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                data_reg   <= '0;
                strobe_reg <= 1'b0;
            end else begin
                strobe_reg <= bus.io_we && sel;
                if (bus.io_we && sel) begin
                    data_reg <= bus.io_dout;
                end
            end
        end

        assign out_data[gi*DATA_W +: DATA_W] = data_reg;
        assign out_strobe[gi]                = strobe_reg;
        assign out_rd[gi]                    = sel ? data_reg : '0;
    end

    for (gi = 0; gi < N_IN; gi++) begin : g_in
        localparam logic [ADDR_W-1:0] DATA_ADDR = IN_BASE + ADDR_W'(IN_STRIDE * gi);
        localparam logic [ADDR_W-1:0] STAT_ADDR = DATA_ADDR + ADDR_W'(STATUS_OFS);

        logic              data_sel;
        logic              stat_sel;
        logic [DATA_W-1:0] buf_data;
        logic              full_bit;
        logic              ovr_bit;
        logic [DATA_W-1:0] status_word;

        assign data_sel = (addr_al == DATA_ADDR);
        assign stat_sel = (addr_al == STAT_ADDR);

        io_in_chan #(
            .DATA_W(DATA_W)
        ) u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  (in_data[gi*DATA_W +: DATA_W]),
            .in_valid (in_valid[gi]),
            .data_rd  (bus.io_rd && data_sel),
            .ovr_clr  (bus.io_we && stat_sel && bus.io_dout[ST_OVR]),
            .buf_data (buf_data),
            .full     (full_bit),
            .ovr      (ovr_bit)
        );

        always_comb begin
            status_word          = '0;
            status_word[ST_FULL] = full_bit;
            status_word[ST_OVR]  = ovr_bit;
        end

        assign full_vec[gi] = full_bit;
        assign in_rd[gi]    = data_sel ? buf_data :
                              stat_sel ? status_word : '0;
    end

    // At most one channel decodes a given address, so OR-ing the masked words is a mux.
    always_comb begin
        bus.io_din = '0;
        for (int i = 0; i < N_OUT; i++) begin
            bus.io_din = bus.io_din | out_rd[i];
        end
        for (int j = 0; j < N_IN; j++) begin
            bus.io_din = bus.io_din | in_rd[j];
        end
    end

    assign irq = |full_vec;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed and randomised bench for mmio_io_ctrl against a behavioural model
// of the register map and the input capture rules.
module tb_mmio_io_ctrl;

    localparam int DW = 32;
    localparam int NO = 2;
    localparam int NI = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mmio_io_ctrl_if #(.DATA_W(DW)) bus ();

    logic [NO*DW-1:0] out_data;
    logic [NO-1:0]    out_strobe;
    logic [NI*DW-1:0] in_data;
    logic [NI-1:0]    in_valid;
    logic             irq;

    mmio_io_ctrl #(
        .DATA_W (DW),
        .N_OUT  (NO),
        .N_IN   (NI),
        .IN_BASE(8'h40)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .out_data  (out_data),
        .out_strobe(out_strobe),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .irq       (irq)
    );

    // Behavioural model state
    logic [DW-1:0] m_out [NO];
    logic [NO-1:0] m_stb;
    logic [DW-1:0] m_buf [NI];
    logic [NI-1:0] m_full;
    logic [NI-1:0] m_ovr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NO; i++) m_out[i] = '0;
        for (int j = 0; j < NI; j++) m_buf[j] = '0;
        m_stb  = '0;
        m_full = '0;
        m_ovr  = '0;
    endtask

    function automatic logic [DW-1:0] m_read(input logic [7:0] a);
        int w;
        int j;
        w = int'(a) & 'hFC;
        if (w < 4 * NO) return m_out[w / 4];
        if (w >= 'h40 && w < 'h40 + 8 * NI) begin
            j = (w - 'h40) / 8;
            if (((w - 'h40) % 8) == 0) return m_buf[j];
            return {30'b0, m_ovr[j], m_full[j]};
        end
        return '0;
    endfunction

    task automatic m_step(input logic [7:0] a, input logic [DW-1:0] d, input logic we,
                          input logic rd, input logic [NI-1:0] vin, input logic [NI*DW-1:0] din);
        int  w;
        logic hit_d, hit_s, new_ovr;
        w = int'(a) & 'hFC;
        for (int i = 0; i < NO; i++) begin
            m_stb[i] = we && (w == 4 * i);
            if (m_stb[i]) m_out[i] = d;
        end
        for (int j = 0; j < NI; j++) begin
            hit_d   = rd && (w == 'h40 + 8 * j);
            hit_s   = we && (w == 'h40 + 8 * j + 4);
            new_ovr = 1'b0;
            if (vin[j]) begin
                if (!m_full[j] || hit_d) begin
                    m_buf[j]  = din[j*DW +: DW];
                    m_full[j] = 1'b1;
                end else begin
                    new_ovr = 1'b1;
                end
            end else if (hit_d) begin
                m_full[j] = 1'b0;
            end
            if (hit_s && d[1]) m_ovr[j] = 1'b0;
            if (new_ovr) m_ovr[j] = 1'b1;
        end
    endtask

    // One bus cycle: drive on the falling edge, check combinational read data
    // before the rising edge, then check registered outputs just after it.
    task automatic cycle(input string tag, input logic [7:0] a, input logic [DW-1:0] d,
                         input logic we, input logic rd, input logic [NI-1:0] vin,
                         input logic [NI*DW-1:0] din);
        logic [NO*DW-1:0] exp_out;
        @(negedge clk);
        bus.io_addr = a;
        bus.io_dout = d;
        bus.io_we   = we;
        bus.io_rd   = rd;
        in_valid    = vin;
        in_data     = din;
        #1;
        rdata = bus.io_din;
        chk({tag, ":io_din"}, 64'(rdata), 64'(m_read(a)));
        @(posedge clk);
        m_step(a, d, we, rd, vin, din);
        #1;
        for (int i = 0; i < NO; i++) exp_out[i*DW +: DW] = m_out[i];
        chk({tag, ":out_data"},   64'(out_data),   64'(exp_out));
        chk({tag, ":out_strobe"}, 64'(out_strobe), 64'(m_stb));
        chk({tag, ":irq"},        64'(irq),        64'(|m_full));
    endtask

    task automatic idle(input string tag, input logic [7:0] a);
        cycle(tag, a, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  pick [9];
        logic [NI*DW-1:0] rdin;
        pick = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h80};

        bus.io_addr = '0;
        bus.io_dout = '0;
        bus.io_we   = 1'b0;
        bus.io_rd   = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst:out_data",   64'(out_data),   64'h0);
        chk("rst:out_strobe", 64'(out_strobe), 64'h0);
        chk("rst:irq",        64'(irq),        64'h0);
        rstn = 1'b1;

        // Output write and readback
        cycle("wr04", 8'h04, 32'hA5A5_0001, 1'b1, 1'b0, '0, '0);
        chk("wr04:hi_word", 64'(out_data[63:32]), 64'hA5A5_0001);
        chk("wr04:strobe",  64'(out_strobe),      64'h2);
        idle("rb04", 8'h04);
        chk("rb04:value",   64'(rdata),           64'hA5A5_0001);
        chk("rb04:no_stb",  64'(out_strobe),      64'h0);

        // Capture then read-clear
        cycle("cap", 8'hFC, '0, 1'b0, 1'b0, 2'b01, 64'h1234);
        idle("cap_st", 8'h44);
        chk("cap:status", 64'(rdata), 64'h1);
        chk("cap:irq",    64'(irq),   64'h1);
        cycle("cap_rd", 8'h40, '0, 1'b0, 1'b1, '0, '0);
        chk("cap:read",   64'(rdata), 64'h1234);
        chk("cap:irq0",   64'(irq),   64'h0);
        idle("cap_st2", 8'h44);
        chk("cap:status0", 64'(rdata), 64'h0);

        // Overrun and clear
        cycle("ovr_a", 8'hFC, '0, 1'b0, 1'b0, 2'b01, 64'h11);
        cycle("ovr_b", 8'hFC, '0, 1'b0, 1'b0, 2'b01, 64'h22);
        idle("ovr_pk", 8'h40);
        chk("ovr:data",   64'(rdata), 64'h11);
        idle("ovr_st", 8'h44);
        chk("ovr:status", 64'(rdata), 64'h3);
        cycle("ovr_clr", 8'h44, 32'h2, 1'b1, 1'b0, '0, '0);
        idle("ovr_st2", 8'h44);
        chk("ovr:cleared", 64'(rdata), 64'h1);

        // Read and capture in the same cycle
        cycle("sim_rd", 8'h40, '0, 1'b0, 1'b1, 2'b01, 64'h33);
        chk("sim:old", 64'(rdata), 64'h11);
        idle("sim_st", 8'h44);
        chk("sim:status", 64'(rdata), 64'h1);
        cycle("sim_rd2", 8'h40, '0, 1'b0, 1'b1, '0, '0);
        chk("sim:new", 64'(rdata), 64'h33);

        // Unmapped and input-data writes are ignored
        cycle("um80", 8'h80, 32'hFFFF, 1'b1, 1'b0, '0, '0);
        chk("um80:strobe", 64'(out_strobe), 64'h0);
        cycle("um40", 8'h40, 32'hFFFF, 1'b1, 1'b0, '0, '0);
        idle("um_rd80", 8'h80);
        chk("um:read80", 64'(rdata), 64'h0);
        idle("um_rd40", 8'h40);
        chk("um:read40", 64'(rdata), 64'h33);

        // Reset in the middle of a write, with a channel full
        cycle("pre_rst", 8'h00, 32'h5, 1'b1, 1'b0, 2'b10, {32'h77, 32'h0});
        @(negedge clk);
        bus.io_addr = 8'h00;
        bus.io_dout = 32'h7;
        bus.io_we   = 1'b1;
        in_valid    = '0;
        #2 rstn = 1'b0;
        #1;
        m_reset();
        chk("mrst:out_data", 64'(out_data), 64'h0);
        chk("mrst:irq",      64'(irq),      64'h0);
        bus.io_addr = 8'h4C;
        #1;
        chk("mrst:status1",  64'(bus.io_din), 64'h0);
        @(negedge clk);
        bus.io_we = 1'b0;
        rstn      = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst:no_strobe", 64'(out_strobe), 64'h0);
        chk("mrst:out_hold",  64'(out_data),   64'h0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pick[$urandom_range(0, 8)];
            ra = ra | 8'($urandom_range(0, 3));
            rdin = {32'($urandom), 32'($urandom)};
            cycle($sformatf("rnd%0d", k), ra, 32'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  NI'($urandom_range(0, 3) & $urandom_range(0, 3)), rdin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
